mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 146 ++++++++++++++
 tb/tb_mem_responder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: single-port word RAM behind a valid/ready request channel
// and a valid/ready response channel. Each accepted request waits LATENCY
// cycles, performs one RAM access, then holds its response until taken.
module mem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_adr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] txn_count
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state_q;
    logic [3:0]  wait_cnt_q;
    logic        we_q;
    logic [31:0] adr_q;
    logic [31:0] wdata_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;
    logic [15:0] txn_count_q;

    logic [31:0] mem [DEPTH];

    // Access-edge view of the request: live inputs when the access happens on
    // the accept edge itself (LATENCY=0), captured copies otherwise.
    logic          acc_fire_d;
    logic          acc_we_d;
    logic          acc_err_d;
    logic [31:0]   acc_adr_d;
    logic [31:0]   acc_wdata_d;
    logic [AW-1:0] acc_idx_d;

    // Select the request being served and decide whether this edge is its RAM access.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        acc_fire_d  = 1'b0;
        acc_we_d    = we_q;
        acc_adr_d   = adr_q;
        acc_wdata_d = wdata_q;
        if (state_q == IDLE) begin
            acc_we_d    = req_we;
            acc_adr_d   = req_adr;
            acc_wdata_d = req_wdata;
            acc_fire_d  = req_valid && (LATENCY == 0);
        end else if (state_q == WAIT) begin
            acc_fire_d  = (wait_cnt_q == 4'd1);
        end
        acc_err_d = (acc_adr_d[1:0] != 2'b00) ||
                    ({2'b00, acc_adr_d[31:2]} >= 32'(DEPTH));
        acc_idx_d = acc_adr_d[AW+1:2];
    end

    // Capture the request at the accept edge; held until the next accept.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (state_q == IDLE && req_valid) begin
            we_q    <= req_we;
            adr_q   <= req_adr;
            wdata_q <= req_wdata;
        end
    end

    // RAM write port; a write landing on a reset edge is suppressed.
    always_ff @(posedge clk) begin
        // NOTE: the RAM array is deliberately not reset, so it maps onto plain memory.
        if (reset && acc_fire_d && acc_we_d && !acc_err_d) begin
            mem[acc_idx_d] <= acc_wdata_d;
        end
    end

    // Control FSM with registered handshake outputs, response data and counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            wait_cnt_q  <= 4'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
            txn_count_q <= 16'd0;
        end else begin
            if (acc_fire_d) begin
                rsp_err_q   <= acc_err_d;
                rsp_rdata_q <= (acc_err_d || acc_we_d) ? 32'd0 : mem[acc_idx_d];
            end
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        req_ready_q <= 1'b0;
                        if (LATENCY == 0) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state_q    <= WAIT;
                            wait_cnt_q <= 4'(LATENCY);
                        end
                    end
                end
                WAIT: begin
                    wait_cnt_q <= wait_cnt_q - 4'd1;
                    if (wait_cnt_q == 4'd1) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        txn_count_q <= txn_count_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign txn_count = txn_count_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench for mem_responder. Instance u_dut uses
// LATENCY=2 with a response scoreboard; instance u_z uses LATENCY=0 for
// streaming and counter-wrap checks.
module tb_mem_responder;

    localparam int LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_adr, req_wdata, rsp_rdata;
    logic [15:0] txn_count;

    logic        z_reset, z_req_valid, z_req_ready, z_req_we, z_rsp_valid, z_rsp_ready, z_rsp_err;
    logic [31:0] z_req_adr, z_req_wdata, z_rsp_rdata;
    logic [15:0] z_txn_count;

    mem_responder #(.DEPTH(64), .LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_adr(req_adr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .txn_count(txn_count)
    );

    mem_responder #(.DEPTH(64), .LATENCY(0)) u_z (
        .clk(clk), .reset(z_reset),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_adr(z_req_adr), .req_wdata(z_req_wdata),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata),
        .rsp_err(z_rsp_err), .txn_count(z_txn_count)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t sb[$];
    int   tests   = 0;
    int   fails   = 0;
    int   exp_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction on u_dut: expectation queued at issue, compared at response.
    task automatic txn(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input int hold,
                       input string tag);
        rsp_t        e;
        int          n;
        logic [31:0] rd0;
        e.rdata = exp_rd;
        e.err   = exp_err;
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_adr = adr; req_wdata = wd; rsp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        check({tag, " req_ready before accept"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        // Scramble the request after acceptance; the DUT must use its captured copy.
        req_valid = 1'b0; req_we = ~we; req_adr = adr ^ 32'h4; req_wdata = ~wd;
        n = 0;
        while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
        check({tag, " latency"}, 32'(n), 32'(LAT));
        e = sb.pop_front();
        check({tag, " rdata"}, rsp_rdata, e.rdata);
        check({tag, " err"}, 32'(rsp_err), 32'(e.err));
        rd0 = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, " held valid"}, 32'(rsp_valid), 32'd1);
            check({tag, " held rdata"}, rsp_rdata, rd0);
            check({tag, " held req_ready"}, 32'(req_ready), 32'd0);
            check({tag, " held count"}, 32'(txn_count), 32'(exp_cnt));
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        exp_cnt++;
        check({tag, " valid after hs"}, 32'(rsp_valid), 32'd0);
        check({tag, " req_ready after hs"}, 32'(req_ready), 32'd1);
        check({tag, " count"}, 32'(txn_count), 32'(exp_cnt));
    endtask

    // Accept a write on u_dut, then pull reset low so it is sampled at edge E0+k.
    task automatic abort_write(input logic [31:0] adr, input logic [31:0] wd, input int k,
                               input string tag);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_adr = adr; req_wdata = wd; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 1; i < k; i++) begin @(posedge clk); #1; end
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        exp_cnt = 0;
        check({tag, " req_ready"}, 32'(req_ready), 32'd1);
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, " count"}, 32'(txn_count), 32'd0);
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_wdata = '0; rsp_ready = 1'b0;
        z_reset = 1'b0; z_req_valid = 1'b0; z_req_we = 1'b0; z_req_adr = '0; z_req_wdata = '0;
        z_rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst req_ready", 32'(req_ready), 32'd1);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rsp_err", 32'(rsp_err), 32'd0);
        check("rst rsp_rdata", rsp_rdata, 32'd0);
        check("rst count", 32'(txn_count), 32'd0);
        reset = 1'b1;
        z_reset = 1'b1;

        // Write then read back, plus the last in-range word.
        txn(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0, "wr10");
        txn(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0, "rd10");
        txn(1'b1, 32'h0, 32'hA5A50000, 32'h0, 1'b0, 0, "wr0");
        txn(1'b1, 32'h4, 32'h44444444, 32'h0, 1'b0, 0, "wr4");
        txn(1'b1, 32'h8, 32'h88888888, 32'h0, 1'b0, 0, "wr8");
        txn(1'b1, 32'hFC, 32'hCAFEF00D, 32'h0, 1'b0, 0, "wrFC");
        txn(1'b0, 32'hFC, 32'h0, 32'hCAFEF00D, 1'b0, 0, "rdFC");

        // Error cases; the bad writes would alias word 0 if the checks were missing.
        txn(1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 0, "rd13");
        txn(1'b1, 32'h100, 32'h11112222, 32'h0, 1'b1, 0, "wr100");
        txn(1'b1, 32'h2, 32'h33334444, 32'h0, 1'b1, 0, "wr2");
        txn(1'b0, 32'h0, 32'h0, 32'hA5A50000, 1'b0, 0, "rd0");

        // Backpressure for five cycles.
        txn(1'b0, 32'h4, 32'h0, 32'h44444444, 1'b0, 5, "bp");

        // Reset during WAIT, and reset on the write's RAM-access edge.
        abort_write(32'h8, 32'h12345678, 1, "abort1");
        txn(1'b0, 32'h8, 32'h0, 32'h88888888, 1'b0, 0, "rd8a");
        abort_write(32'h8, 32'h99999999, 2, "abort2");
        txn(1'b0, 32'h8, 32'h0, 32'h88888888, 1'b0, 0, "rd8b");
        check("scoreboard drained", 32'(sb.size()), 32'd0);

        // LATENCY=0 streaming: req_valid and rsp_ready held high.
        z_req_valid = 1'b1;
        z_rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            z_req_we    = (i < 4);
            z_req_adr   = 32'(i % 4) * 32'd4;
            z_req_wdata = 32'h1000 + 32'(i);
            @(posedge clk); #1;
            if (i == 7) z_req_valid = 1'b0;
            check("z rsp_valid on", 32'(z_rsp_valid), 32'd1);
            check("z rdata", z_rsp_rdata, (i < 4) ? 32'h0 : 32'h1000 + 32'(i - 4));
            check("z err", 32'(z_rsp_err), 32'd0);
            @(posedge clk); #1;
            check("z rsp_valid off", 32'(z_rsp_valid), 32'd0);
            check("z count", 32'(z_txn_count), 32'(i + 1));
        end

        // Counter wrap: preset to FFFF, then one more transaction.
        @(negedge clk);
        force u_z.txn_count_q = 16'hFFFF;
        #1;
        release u_z.txn_count_q;
        @(negedge clk);
        z_req_valid = 1'b1; z_req_we = 1'b0; z_req_adr = 32'h0;
        @(posedge clk); #1;
        z_req_valid = 1'b0;
        check("z count preset", 32'(z_txn_count), 32'hFFFF);
        @(posedge clk); #1;
        check("z count wrap", 32'(z_txn_count), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
